// File: rtl/bsg_mesh_router_pkg.sv
// Shared mesh-router definitions: DOR header struct generator and injector FSM states.

// Declares bsg_mesh_dor_hdr_s for the given coordinate/length widths.
// The x coordinate sits in the LSBs, then y, then the body length.
`define BSG_MESH_DOR_HDR_S_MACRO(x_w, y_w, len_w) \
    typedef struct packed {                        \
        logic [len_w-1:0] len;                     \
        logic [y_w-1:0]   y;                       \
        logic [x_w-1:0]   x;                       \
    } bsg_mesh_dor_hdr_s;

package bsg_mesh_router_pkg;

    // Injector packet-sequencing states.
    typedef enum logic [1:0] {
        e_inj_idle = 2'd0,
        e_inj_hdr  = 2'd1,
        e_inj_body = 2'd2
    } bsg_mesh_dor_inj_state_e;

    // Bits needed to hold a body-flit count of 0..max_body_flits.
    function automatic int len_width(input int max_body_flits);
        return $clog2(max_body_flits + 1);
    endfunction

endpackage

// File: rtl/bsg_mesh_dor_flit_serializer.sv
// Holds a captured packet payload and walks its body flits one at a time.
// The parent loads it on request acceptance, clears the counter when the
// header leaves, and advances it on every non-final body handshake.

module bsg_mesh_dor_flit_serializer
    import bsg_mesh_router_pkg::*;
#(
    parameter int flit_width_p      = 32,
    parameter int max_body_flits_p  = 4,
    parameter int len_width_lp      = len_width(max_body_flits_p),
    parameter int payload_width_lp  = flit_width_p * max_body_flits_p
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        load_i,
    input  logic [payload_width_lp-1:0] data_i,
    input  logic [len_width_lp-1:0]     len_i,
    input  logic                        clear_cnt_i,
    input  logic                        advance_i,
    output logic [flit_width_p-1:0]     flit_o,
    output logic                        len_zero_o,
    output logic                        last_o
);

    logic [payload_width_lp-1:0] payload_q, payload_d;
    logic [len_width_lp-1:0]     len_q, len_d;
    logic [len_width_lp-1:0]     cnt_q, cnt_d;

    // Next-state for payload, length and body-flit counter.
    always_comb begin
        payload_d = payload_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        if (load_i) begin
            payload_d = data_i;
            len_d     = len_i;
            cnt_d     = '0;
        end else if (clear_cnt_i) begin
            cnt_d     = '0;
        end else if (advance_i) begin
            cnt_d     = cnt_q + len_width_lp'(1);
        end else begin
            cnt_d     = cnt_q;
        end
    end

    // Payload, length and counter registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            payload_q <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
        end else begin
            payload_q <= payload_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
        end
    end

    // cnt_q stays below len_q <= max_body_flits_p, so the select is in range.
    assign flit_o     = payload_q[int'(cnt_q) * flit_width_p +: flit_width_p];
    assign len_zero_o = (len_q == '0);
    assign last_o     = (cnt_q == (len_q - len_width_lp'(1)));

endmodule

// File: rtl/bsg_mesh_dor_packet_injector.sv
// Source-side DOR packet injector: accepts a client request, encodes the
// header flit and serializes header + body flits into a router's P port.

module bsg_mesh_dor_packet_injector
    import bsg_mesh_router_pkg::*;
#(
    parameter int x_cord_width_p    = -1,
    parameter int y_cord_width_p    = -1,
    parameter int flit_width_p      = 32,
    parameter int max_body_flits_p  = 4,
    localparam int len_width_lp     = len_width(max_body_flits_p),
    localparam int payload_width_lp = flit_width_p * max_body_flits_p
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [x_cord_width_p-1:0]   my_x_i,
    input  logic [y_cord_width_p-1:0]   my_y_i,
    input  logic                        v_i,
    input  logic [x_cord_width_p-1:0]   dest_x_i,
    input  logic [y_cord_width_p-1:0]   dest_y_i,
    input  logic [len_width_lp-1:0]     len_i,
    input  logic [payload_width_lp-1:0] data_i,
    output logic                        ready_o,
    output logic                        v_o,
    output logic [flit_width_p-1:0]     data_o,
    input  logic                        ready_i,
    output logic                        err_o
);

    if (x_cord_width_p <= 0 || y_cord_width_p <= 0 || max_body_flits_p < 1) begin : g_bad_cfg
        $fatal(1, "bsg_mesh_dor_packet_injector: coordinate widths and max_body_flits_p must be set");
    end
    if (flit_width_p < x_cord_width_p + y_cord_width_p + len_width_lp) begin : g_bad_width
        $fatal(1, "bsg_mesh_dor_packet_injector: header does not fit in flit_width_p");
    end

    `BSG_MESH_DOR_HDR_S_MACRO(x_cord_width_p, y_cord_width_p, len_width_lp)

    bsg_mesh_dor_inj_state_e     state_q, state_d;
    bsg_mesh_dor_hdr_s           hdr_q, hdr_d;
    logic                        err_q, err_d;
    logic [x_cord_width_p-1:0]   my_x_q, my_x_d;
    logic [y_cord_width_p-1:0]   my_y_q, my_y_d;

    logic                        accept_s;
    logic                        len_ok_s;
    logic                        good_accept_s;
    logic                        hdr_fire_s;
    logic                        body_fire_s;
    logic                        last_fire_s;
    logic                        len_zero_s;
    logic                        last_s;
    logic [flit_width_p-1:0]     body_flit_s;

    // ready_o depends only on state and the router handshake, never on v_i.
    assign last_fire_s   = (hdr_fire_s & len_zero_s) | (body_fire_s & last_s);
    assign ready_o       = (state_q == e_inj_idle) | last_fire_s;
    assign accept_s      = v_i & ready_o;
    assign len_ok_s      = (len_i <= len_width_lp'(max_body_flits_p));
    assign good_accept_s = accept_s & len_ok_s;
    assign hdr_fire_s    = (state_q == e_inj_hdr) & ready_i;
    assign body_fire_s   = (state_q == e_inj_body) & ready_i;
    assign v_o           = (state_q != e_inj_idle);
    assign err_o         = err_q;

    bsg_mesh_dor_flit_serializer #(
        .flit_width_p     (flit_width_p),
        .max_body_flits_p (max_body_flits_p),
        .len_width_lp     (len_width_lp),
        .payload_width_lp (payload_width_lp)
    ) serializer (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .load_i      (good_accept_s),
        .data_i      (data_i),
        .len_i       (len_i),
        .clear_cnt_i (hdr_fire_s),
        .advance_i   (body_fire_s & ~last_s),
        .flit_o      (body_flit_s),
        .len_zero_o  (len_zero_s),
        .last_o      (last_s)
    );

    // Next state, header capture, sticky error and tile-coordinate sampling.
    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        err_d   = err_q | (accept_s & ~len_ok_s);
        my_x_d  = my_x_i;
        my_y_d  = my_y_i;
        if (good_accept_s) begin
            hdr_d = '{len: len_i, y: dest_y_i, x: dest_x_i};
        end else begin
            hdr_d = hdr_q;
        end
        case (state_q)
            e_inj_idle: begin
                state_d = good_accept_s ? e_inj_hdr : e_inj_idle;
            end
            e_inj_hdr: begin
                if (!ready_i) begin
                    state_d = e_inj_hdr;
                end else if (len_zero_s) begin
                    state_d = good_accept_s ? e_inj_hdr : e_inj_idle;
                end else begin
                    state_d = e_inj_body;
                end
            end
            e_inj_body: begin
                if (ready_i && last_s) begin
                    state_d = good_accept_s ? e_inj_hdr : e_inj_idle;
                end else begin
                    state_d = e_inj_body;
                end
            end
            default: begin
                state_d = e_inj_idle;
            end
        endcase
    end

    // FSM state and control registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= e_inj_idle;
            hdr_q   <= '0;
            err_q   <= 1'b0;
            my_x_q  <= '0;
            my_y_q  <= '0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            err_q   <= err_d;
            my_x_q  <= my_x_d;
            my_y_q  <= my_y_d;
        end
    end

    // Flit mux; while idle the link shows this tile's sampled coordinate.
    always_comb begin
        data_o = '0;
        case (state_q)
            e_inj_hdr:  data_o = flit_width_p'(hdr_q);
            e_inj_body: data_o = body_flit_s;
            default:    data_o = flit_width_p'({my_y_q, my_x_q});
        endcase
    end

endmodule

// File: tb/tb_bsg_mesh_dor_packet_injector.sv
// Directed table-driven bench for bsg_mesh_dor_packet_injector
// (x=y=4 bits, flit=32, max body flits=4, tile (2,3)).

module tb_bsg_mesh_dor_packet_injector;

    localparam int XW  = 4;
    localparam int YW  = 4;
    localparam int FW  = 32;
    localparam int MX  = 4;
    localparam int LW  = 3;
    localparam int PW  = FW * MX;

    logic          clk;
    logic          reset_n;
    logic [XW-1:0] my_x, my_y_dummy;
    logic [YW-1:0] my_y;
    logic          v_in;
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    logic [LW-1:0] len;
    logic [PW-1:0] data_in;
    logic          ready_out;
    logic          v_out;
    logic [FW-1:0] data_out;
    logic          ready_in;
    logic          err_out;

    int n_cmp = 0;
    int n_bad = 0;

    bsg_mesh_dor_packet_injector #(
        .x_cord_width_p   (XW),
        .y_cord_width_p   (YW),
        .flit_width_p     (FW),
        .max_body_flits_p (MX)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .my_x_i    (my_x),
        .my_y_i    (my_y),
        .v_i       (v_in),
        .dest_x_i  (dx),
        .dest_y_i  (dy),
        .len_i     (len),
        .data_i    (data_in),
        .ready_o   (ready_out),
        .v_o       (v_out),
        .data_o    (data_out),
        .ready_i   (ready_in),
        .err_o     (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          v;
        logic [XW-1:0] dx;
        logic [YW-1:0] dy;
        logic [LW-1:0] len;
        logic [PW-1:0] data;
        logic          rdy;
        logic          e_ready;
        logic          e_v;
        logic [FW-1:0] e_data;
        logic          e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic v, input logic [XW-1:0] x,
                       input logic [YW-1:0] y, input logic [LW-1:0] l,
                       input logic [PW-1:0] d, input logic rdy,
                       input logic e_ready, input logic e_v,
                       input logic [FW-1:0] e_data, input logic e_err);
        vec_t t;
        t.rst_n = rst_n; t.v = v; t.dx = x; t.dy = y; t.len = l; t.data = d;
        t.rdy = rdy; t.e_ready = e_ready; t.e_v = e_v; t.e_data = e_data; t.e_err = e_err;
        vecs.push_back(t);
    endtask

    function automatic logic [PW-1:0] pl(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                         input logic [FW-1:0] c, input logic [FW-1:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        logic [PW-1:0] junk;
        logic [PW-1:0] p4;
        int            nflits;
        bit            done;

        junk = {4{32'hDEAD_BEEF}};
        my_x = 4'd2; my_y = 4'd3; my_y_dummy = 4'd0;
        reset_n = 1'b0; v_in = 1'b0; dx = 4'd0; dy = 4'd0; len = 3'd0;
        data_in = '0; ready_in = 1'b1;

        //   rst  v  dx    dy    len   data                                              rdy   rdy_o v_o   data_o          err
        // 1: header encode, then two body flits; input payload scrambled after accept
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b1, 1'b0, 32'h0,          1'b0);
        add(1'b1, 1'b1, 4'd5, 4'd1, 3'd2, pl(32'hA0A0_0001, 32'hA0A0_0002, 32'h0, 32'h0), 1'b1, 1'b1, 1'b0, 32'h0,          1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, junk,                                           1'b1, 1'b0, 1'b1, 32'h0000_0215,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, junk,                                           1'b1, 1'b0, 1'b1, 32'hA0A0_0001,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, junk,                                           1'b1, 1'b1, 1'b1, 32'hA0A0_0002,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b1, 1'b0, 32'h0,          1'b0);
        // 2: back-to-back len=1 packets with v_i held
        add(1'b1, 1'b1, 4'd1, 4'd2, 3'd1, pl(32'h0000_00B1, 32'h0, 32'h0, 32'h0),         1'b1, 1'b1, 1'b0, 32'h0,          1'b0);
        add(1'b1, 1'b1, 4'd3, 4'd0, 3'd1, pl(32'h0000_00C1, 32'h0, 32'h0, 32'h0),         1'b1, 1'b0, 1'b1, 32'h0000_0121,  1'b0);
        add(1'b1, 1'b1, 4'd3, 4'd0, 3'd1, pl(32'h0000_00C1, 32'h0, 32'h0, 32'h0),         1'b1, 1'b1, 1'b1, 32'h0000_00B1,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b0, 1'b1, 32'h0000_0103,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b1, 1'b1, 32'h0000_00C1,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b1, 1'b0, 32'h0,          1'b0);
        // 3: backpressure for 5 cycles in BODY; dest is this tile; a request waits meanwhile
        add(1'b1, 1'b1, 4'd2, 4'd3, 3'd2, pl(32'h0000_00E0, 32'h0000_00E1, 32'h0, 32'h0), 1'b1, 1'b1, 1'b0, 32'h0,          1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b0, 1'b1, 32'h0000_0232,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b0, 1'b0, 1'b1, 32'h0000_00E0,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b0, 1'b0, 1'b1, 32'h0000_00E0,  1'b0);
        add(1'b1, 1'b1, 4'd9, 4'd9, 3'd1, junk,                                           1'b0, 1'b0, 1'b1, 32'h0000_00E0,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b0, 1'b0, 1'b1, 32'h0000_00E0,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b0, 1'b0, 1'b1, 32'h0000_00E0,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b0, 1'b1, 32'h0000_00E0,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b1, 1'b1, 32'h0000_00E1,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b1, 1'b0, 32'h0,          1'b0);
        // 4: len=0, header only, held once by backpressure
        add(1'b1, 1'b1, 4'd7, 4'd4, 3'd0, junk,                                           1'b1, 1'b1, 1'b0, 32'h0,          1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b0, 1'b0, 1'b1, 32'h0000_0047,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b1, 1'b1, 32'h0000_0047,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b1, 1'b0, 32'h0,          1'b0);
        // 5: len=7 consumed silently, sticky error across a later good packet
        add(1'b1, 1'b1, 4'd1, 4'd1, 3'd7, junk,                                           1'b1, 1'b1, 1'b0, 32'h0,          1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b1, 1'b0, 32'h0,          1'b1);
        add(1'b1, 1'b1, 4'd4, 4'd5, 3'd1, pl(32'h0000_00F1, 32'h0, 32'h0, 32'h0),         1'b1, 1'b1, 1'b0, 32'h0,          1'b1);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b0, 1'b1, 32'h0000_0154,  1'b1);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b1, 1'b1, 32'h0000_00F1,  1'b1);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b1, 1'b0, 32'h0,          1'b1);
        // 6: reset during body flit 1, then a fresh packet
        add(1'b1, 1'b1, 4'd6, 4'd2, 3'd3, pl(32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 32'h0), 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b0, 1'b1, 32'h0000_0326,  1'b1);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b0, 1'b1, 32'h6000_0000,  1'b1);
        add(1'b0, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b0, 1'b1, 32'h6000_0001,  1'b1);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b1, 1'b0, 32'h0,          1'b0);
        add(1'b1, 1'b1, 4'd5, 4'd1, 3'd1, pl(32'h7000_0000, 32'h0, 32'h0, 32'h0),         1'b1, 1'b1, 1'b0, 32'h0,          1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b0, 1'b1, 32'h0000_0115,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b1, 1'b1, 32'h7000_0000,  1'b0);
        add(1'b1, 1'b0, 4'd0, 4'd0, 3'd0, '0,                                             1'b1, 1'b1, 1'b0, 32'h0,          1'b0);

        // hold reset for two clock edges
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset_n  = vecs[i].rst_n;
            v_in     = vecs[i].v;
            dx       = vecs[i].dx;
            dy       = vecs[i].dy;
            len      = vecs[i].len;
            data_in  = vecs[i].data;
            ready_in = vecs[i].rdy;
            #1;
            chk($sformatf("row%0d ready_o", i), {31'd0, ready_out}, {31'd0, vecs[i].e_ready});
            chk($sformatf("row%0d v_o", i),     {31'd0, v_out},     {31'd0, vecs[i].e_v});
            chk($sformatf("row%0d err_o", i),   {31'd0, err_out},   {31'd0, vecs[i].e_err});
            if (vecs[i].e_v) begin
                chk($sformatf("row%0d data_o", i), data_out, vecs[i].e_data);
            end
        end

        // Max-length packet: exactly 1+4 consecutive link cycles, flits in order.
        p4 = pl(32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003);
        @(negedge clk);
        v_in = 1'b1; dx = 4'd0; dy = 4'd15; len = 3'd4; data_in = p4; ready_in = 1'b1;
        #1;
        chk("len4 accept ready_o", {31'd0, ready_out}, 32'd1);
        nflits = 0;
        done   = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            v_in = 1'b0;
            data_in = junk;
            #1;
            if (v_out) begin
                chk($sformatf("len4 flit%0d", nflits), data_out,
                    (nflits == 0) ? 32'h0000_04F0 : (32'hD000_0000 + 32'(nflits - 1)));
                nflits++;
            end else if (nflits > 0) begin
                done = 1'b1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL len4 timeout: got %0d flits with v_o still high or never seen, expected packet end", nflits);
        end
        chk("len4 link cycles", 32'(nflits), 32'd5);
        chk("len4 err_o", {31'd0, err_out}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
